trojan_activity_monitor: RTL
============================

# trojan_activity_monitor

Runtime detection stage placed directly downstream of the instrumented `full_adder`. It watches the adder operand inputs for the known trigger signature (`a,b,cin` = 111 held for consecutive cycles). After that signature it opens a fixed observation window on a tapped internal bus and counts how many cycles the bus changes value. If the activity count exceeds a threshold, it raises a sticky alarm. The block replaces the bench-only toggle check with synthesizable on-chip logic.

## Interface
Parameters:
- `WIDTH`, 16, width of observed bus (tapped from `trojan_shift_reg`)
- `TRIG_LEN`, 6, consecutive 111 cycles that constitute the trigger
- `WINDOW`, 50, observation window length in cycles
- `THRESH`, 5, alarm when toggle count is strictly greater than this
- `CW`, $clog2(WINDOW+1), toggle counter width (derived)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  monitor enable
- `a`, `b`, `cin`  in  1 each  adder operand taps
- `obs_bus`  in  WIDTH  observed internal register
- `alarm_clr`  in  1  synchronous clear of alarm and detection state
- `alarm`  out  1  sticky Trojan alarm
- `trig_seen`  out  1  trigger signature detected in current episode
- `window_done`  out  1  one-cycle pulse at window end
- `toggle_cnt`  out  CW  toggles counted in current/last window
- `state`  out  2  FSM state: IDLE=0, ARMED=1, WINDOW=2, ALARM=3

## Operation
- All outputs and internal registers are registered. During `rst_n`=0 everything is 0 and `state`=IDLE. Reset applies immediately and does not wait for `clk`.
- **IDLE:** counters held at 0. When `en`=1, go to ARMED.
- **ARMED:**
  - Run counter increments when `a&b&cin`=1 and clears to 0 otherwise.
  - When the run counter equals TRIG_LEN-1 and `a&b&cin`=1, at that edge:
    - go to WINDOW,
    - set `trig_seen`=1,
    - capture `prev`<=`obs_bus`,
    - clear `toggle_cnt` and the window counter.
  - Otherwise the run counter does not saturate or wrap. A trigger always fires exactly at the TRIG_LEN-th consecutive cycle.
- **WINDOW:**
  - On each edge, if `obs_bus` != `prev`, then `toggle_cnt`++ (saturating at 2^CW-1) and `prev`<=`obs_bus`.
  - The window counter increments.
  - Operand inputs are ignored.
  - On the edge where the window counter equals WINDOW-1:
    - `window_done`<=1 for one cycle,
    - if the updated count (including this cycle's toggle) > THRESH, go to ALARM and set `alarm`=1,
    - else go to ARMED, clearing `trig_seen` and the run counter.
  - `toggle_cnt` holds its final value until the next window starts or `alarm_clr`.
- **ALARM:** `alarm`=1 and holds. `en` is ignored. Only `alarm_clr` or reset leaves this state. On `alarm_clr`, go to ARMED if `en`=1, else IDLE; clear `alarm`, `trig_seen`, `toggle_cnt` and the run counter.
- **`en`=0 in ARMED or WINDOW:** go to IDLE next edge. Any window in progress is aborted, with no `window_done` and no alarm; counters and `trig_seen` clear.
- **`alarm_clr` in ARMED/WINDOW:** same effect as an abort, but the next state is ARMED (if `en`=1).
- **Priority when events coincide:** reset > `alarm_clr` > `en`=0 > window-end decision > toggle counting.

## Timing
- Trigger latency: `trig_seen` and `state`=WINDOW are visible after the edge that samples the TRIG_LEN-th consecutive 111.
- Window covers exactly WINDOW sampling edges after entry, the first at entry+1.
- `window_done` and the ALARM/ARMED decision are visible after the WINDOW-th edge; `alarm` rises on that same edge.
- `alarm_clr` takes effect one edge later; `alarm` falls on that edge.
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs, then assert `rst_n`=0 mid-WINDOW without a clock edge -> all outputs 0 and `state`=0 immediately.
- **Trigger boundary:** `en`=1, 111 for 5 cycles, then 000 -> `trig_seen` stays 0 and the run counter restarts. Then 111 for 6 cycles -> `trig_seen`=1 and `state`=2 after the 6th edge.
- **Active Trojan:** after trigger, `obs_bus` changes every cycle for 50 cycles -> `toggle_cnt`=50, `window_done` pulses once, `alarm`=1, `state`=3 after the 50th edge. `alarm` stays 1 for 20 further cycles even with `en`=0.
- **Threshold edge:** exactly 5 toggles in window -> `toggle_cnt`=5, `alarm`=0, `state`=1. Exactly 6 toggles, with the 6th on the final window cycle -> `alarm`=1.
- **Clear/abort:** in ALARM, pulse `alarm_clr` -> next edge `alarm`=0, `state`=1, `toggle_cnt`=0. Separately, drop `en` at window cycle 20 -> `state`=0, with no `window_done` and no `alarm`.
- **Coincidence:** `alarm_clr` on the same edge as the window end with >5 toggles -> `alarm` stays 0, `state`=1, `window_done`=0.

Source files
------------

// File: rtl/trojan_activity_monitor.sv
// Runtime Trojan activity monitor: detects the a/b/cin=111 trigger run, then counts
// toggles on a tapped bus over a fixed window and raises a sticky alarm on excess activity.
module trojan_activity_monitor #(
    parameter int WIDTH    = 16,
    parameter int TRIG_LEN = 6,
    parameter int WINDOW   = 50,
    parameter int THRESH   = 5,
    parameter int CW       = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic [WIDTH-1:0] obs_bus,
    input  logic             alarm_clr,
    output logic             alarm,
    output logic             trig_seen,
    output logic             window_done,
    output logic [CW-1:0]    toggle_cnt,
    output logic [1:0]       state
);

    localparam int RW = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [RW-1:0] RUN_LAST = RW'(TRIG_LEN - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        WINDOW_ST = 2'd2,
        ALARM  = 2'd3
    } state_t;

    state_t          r_state;
    logic [RW-1:0]   r_run_cnt;
    logic [WW-1:0]   r_win_cnt;
    logic [WIDTH-1:0] r_prev;
    logic [CW-1:0]   r_toggle_cnt;
    logic            r_alarm;
    logic            r_trig_seen;
    logic            r_window_done;

    state_t          w_state_nxt;
    logic [RW-1:0]   w_run_nxt;
    logic [WW-1:0]   w_win_nxt;
    logic [WIDTH-1:0] w_prev_nxt;
    logic [CW-1:0]   w_toggle_nxt;
    logic            w_alarm_nxt;
    logic            w_trig_nxt;
    logic            w_window_done_nxt;

    logic            w_trig_hit;
    logic            w_bus_changed;
    logic [CW-1:0]   w_tog_upd;

    assign w_trig_hit    = a & b & cin;
    assign w_bus_changed = (obs_bus != r_prev);

    // Toggle count including this cycle's change, saturating at the counter's maximum.
    assign w_tog_upd = (w_bus_changed && (r_toggle_cnt != CNT_MAX))
                       ? r_toggle_cnt + CW'(1) : r_toggle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_run_cnt     <= '0;
            r_win_cnt     <= '0;
            r_prev        <= '0;
            r_toggle_cnt  <= '0;
            r_alarm       <= 1'b0;
            r_trig_seen   <= 1'b0;
            r_window_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_run_cnt     <= w_run_nxt;
            r_win_cnt     <= w_win_nxt;
            r_prev        <= w_prev_nxt;
            r_toggle_cnt  <= w_toggle_nxt;
            r_alarm       <= w_alarm_nxt;
            r_trig_seen   <= w_trig_nxt;
            r_window_done <= w_window_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_run_nxt         = r_run_cnt;
        w_win_nxt         = r_win_cnt;
        w_prev_nxt        = r_prev;
        w_toggle_nxt      = r_toggle_cnt;
        w_alarm_nxt       = r_alarm;
        w_trig_nxt        = r_trig_seen;
        w_window_done_nxt = 1'b0;

        if (alarm_clr) begin
            // Clear outranks everything, including a coincident window-end decision.
            w_run_nxt    = '0;
            w_win_nxt    = '0;
            w_toggle_nxt = '0;
            w_trig_nxt   = 1'b0;
            w_alarm_nxt  = 1'b0;
            w_state_nxt  = en ? ARMED : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_run_nxt    = '0;
                    w_win_nxt    = '0;
                    w_toggle_nxt = '0;
                    w_trig_nxt   = 1'b0;
                    w_alarm_nxt  = 1'b0;
                    if (en) begin
                        w_state_nxt = ARMED;
                    end
                end

                ARMED: begin
                    if (!en) begin
                        w_run_nxt    = '0;
                        w_win_nxt    = '0;
                        w_toggle_nxt = '0;
                        w_trig_nxt   = 1'b0;
                        w_state_nxt  = IDLE;
                    end else if (w_trig_hit) begin
                        if (r_run_cnt == RUN_LAST) begin
                            w_state_nxt  = WINDOW_ST;
                            w_trig_nxt   = 1'b1;
                            w_prev_nxt   = obs_bus;
                            w_toggle_nxt = '0;
                            w_win_nxt    = '0;
                            w_run_nxt    = '0;
                        end else begin
                            w_run_nxt = r_run_cnt + RW'(1);
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end

                WINDOW_ST: begin
                    if (!en) begin
                        w_run_nxt    = '0;
                        w_win_nxt    = '0;
                        w_toggle_nxt = '0;
                        w_trig_nxt   = 1'b0;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_toggle_nxt = w_tog_upd;
                        w_prev_nxt   = obs_bus;
                        w_win_nxt    = r_win_cnt + WW'(1);
                        if (r_win_cnt == WIN_LAST) begin
                            w_window_done_nxt = 1'b1;
                            w_win_nxt         = '0;
                            if (int'(w_tog_upd) > THRESH) begin
                                w_state_nxt = ALARM;
                                w_alarm_nxt = 1'b1;
                            end else begin
                                w_state_nxt = ARMED;
                                w_trig_nxt  = 1'b0;
                                w_run_nxt   = '0;
                            end
                        end
                    end
                end

                ALARM: begin
                    // Sticky: en is ignored; only alarm_clr (handled above) or reset exits.
                    w_alarm_nxt = 1'b1;
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign alarm       = r_alarm;
    assign trig_seen   = r_trig_seen;
    assign window_done = r_window_done;
    assign toggle_cnt  = r_toggle_cnt;
    assign state       = r_state;

endmodule
